sprite_animator: RTL and testbench
==================================

Name: sprite_animator

Overview:
Parametrised successor to the single-sprite mover. One go pulse moves a sprite by STEP pixels in the requested direction, clamped to the screen. It erases the old footprint with a background colour, then redraws the sprite at the new position. Sprite pixels come from an external synchronous sprite ROM. The block sits between the game-tick controller and the VGA adapter's plot port; one instance is used per sprite (pac-man, each ghost).

Parameters:
X_W, 8, width of x coordinates
Y_W, 7, width of y coordinates
SCREEN_W, 160, screen width in pixels
SCREEN_H, 120, screen height in pixels
SPR_W, 20, sprite width in pixels
SPR_H, 20, sprite height in pixels
STEP, 7, pixels moved per go
ADDR_W, 9, sprite ROM address width; must satisfy 2^ADDR_W >= SPR_W*SPR_H
BG_COLOUR, 3'b000, colour used for erase

Ports:
clock  in  1  system clock
resetn  in  1  reset, synchronous, active-low
go  in  1  request one move+redraw; sampled only in IDLE
load  in  1  load init_x/init_y as the position; sampled only in IDLE
init_x  in  X_W  load x
init_y  in  Y_W  load y
up, down, left, right  in  1 each  direction keys, active-low
rom_addr  out  ADDR_W  sprite ROM address, row-major (cy*SPR_W+cx)
rom_data  in  3  ROM colour, valid one cycle after rom_addr
vga_x  out  X_W  pixel x
vga_y  out  Y_W  pixel y
colour  out  3  pixel colour
plot  out  1  pixel write strobe
pos_x  out  X_W  committed sprite x (top-left)
pos_y  out  Y_W  committed sprite y
busy  out  1  high when not in IDLE
done  out  1  one-cycle pulse at end of sequence

Behaviour:
- Reset (resetn=0 at a clock edge, from any state, including mid-raster): state goes to IDLE. pos_x, pos_y, vga_x, vga_y, colour, rom_addr and the drawn flag clear to 0. plot, done and busy are 0.
- States: IDLE, MOVE, ERASE, DRAW, FIN.
- IDLE:
  - load=1: pos takes init_x/init_y; drawn flag clears; stay in IDLE.
  - Otherwise go=1: go to MOVE.
  - load wins over go when both are high.
  - go and load are ignored while busy.
- MOVE (1 cycle): compute next position from the keys.
  - Priority up > down > left > right; all keys high gives no move.
  - up: ny = (y>=STEP) ? y-STEP : 0.
  - down: ny = min(y+STEP, SCREEN_H-SPR_H).
  - left: nx = (x>=STEP) ? x-STEP : 0.
  - right: nx = min(x+STEP, SCREEN_W-SPR_W).
  - All arithmetic is done one bit wider than the operands, so there is no wrap-around.
  - Next state is ERASE if the drawn flag is set and (nx,ny) differs from (pos_x,pos_y); otherwise DRAW.
- Raster phase (ERASE or DRAW), N = SPR_W*SPR_H:
  - Takes N address cycles plus 1 flush cycle.
  - Counters cx (0..SPR_W-1, inner) and cy (0..SPR_H-1) drive rom_addr.
  - vga_x, vga_y, colour and plot are registered, aligned to ROM latency: plot is high for exactly N consecutive cycles, starting one cycle after the first address.
  - Pixel (cx,cy) outputs vga_x = base_x+cx, vga_y = base_y+cy.
  - ERASE: base is the old pos; colour = BG_COLOUR; rom_data is ignored.
  - DRAW: base is the new position; colour = rom_data.
- ERASE -> DRAW after its flush cycle.
- DRAW -> FIN after its flush cycle. On that transition pos_x/pos_y commit to the new position and the drawn flag sets.
- FIN (1 cycle): done=1, then IDLE.
- Timing, with go sampled at edge 0:
  - With erase: plots occupy cycles 3..N+2 and N+4..2N+3; done is in cycle 2N+4.
  - Without erase: plots occupy cycles 3..N+2; done is in cycle N+3.
- pos_x/pos_y hold the old value until commit. A reset mid-sequence therefore never exposes a partial position.
- Key changes after MOVE have no effect on the current sequence.

Test Plan:
- Reset, load (50,60), go with all keys high -> no erase; 400 plots at x 50..69, y 60..79 with colour = rom_data; done at cycle 403; pos = (50,60).
- From (50,60) drawn, go with right=0 -> 400 erase plots of colour 000 at x 50..69, then 400 draw plots at x 57..76; done at cycle 804; pos = (57,60).
- pos (3,100), go with left=0 and down=0 -> down wins; ny clamps to 100 (=120-20) and x stays 3, so there is no erase; pos is unchanged at (3,100).
- pos (3,40), left=0 -> nx=0 (clamped, no wrap to 252); erase at x 3, draw at x 0.
- Pulse go and load during DRAW -> both are ignored; busy stays 1; a single done.
- Assert resetn=0 at plot #150 of ERASE -> next cycle plot=0, busy=0, pos=(0,0); a following go draws at (0,0) with no erase.

Source files
------------

// File: rtl/sprite_animator.sv
// sprite_animator: moves one sprite by STEP pixels per go, erasing the old
// footprint and redrawing it from an external synchronous sprite ROM.
module sprite_animator #(
    parameter int X_W = 8,
    parameter int Y_W = 7,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int SPR_W = 20,
    parameter int SPR_H = 20,
    parameter int STEP = 7,
    parameter int ADDR_W = 9,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              go,
    input  logic              load,
    input  logic [X_W-1:0]    init_x,
    input  logic [Y_W-1:0]    init_y,
    input  logic              up,
    input  logic              down,
    input  logic              left,
    input  logic              right,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [2:0]        rom_data,
    output logic [X_W-1:0]    vga_x,
    output logic [Y_W-1:0]    vga_y,
    output logic [2:0]        colour,
    output logic              plot,
    output logic [X_W-1:0]    pos_x,
    output logic [Y_W-1:0]    pos_y,
    output logic              busy,
    output logic              done
);
    localparam int CX_W = $clog2(SPR_W + 1);
    localparam int CY_W = $clog2(SPR_H + 1);
    localparam logic [X_W:0] STEP_X = (X_W + 1)'(STEP);
    localparam logic [Y_W:0] STEP_Y = (Y_W + 1)'(STEP);
    localparam logic [X_W:0] X_MAX = (X_W + 1)'(SCREEN_W - SPR_W);
    localparam logic [Y_W:0] Y_MAX = (Y_W + 1)'(SCREEN_H - SPR_H);
    localparam logic [CX_W-1:0] CX_LAST = CX_W'(SPR_W - 1);
    localparam logic [CY_W-1:0] CY_LAST = CY_W'(SPR_H - 1);

    typedef enum logic [2:0] {IDLE, MOVE, ERASE, DRAW, FIN} state_t;

    state_t state, state_n;

    logic [X_W-1:0]  new_x, mv_x, base_x;
    logic [Y_W-1:0]  new_y, mv_y, base_y;
    logic [X_W:0]    wide_x;
    logic [Y_W:0]    wide_y;
    logic [CX_W-1:0] cx;
    logic [CY_W-1:0] cy;
    logic            drawn, flushing, draw_q, last;
    logic [2:0]      colour_q;

    // Candidate position, computed one bit wide so clamps never wrap.
    always_comb begin
        wide_x = {1'b0, pos_x};
        wide_y = {1'b0, pos_y};
        mv_x = pos_x;
        mv_y = pos_y;
        if (!up) begin
            mv_y = (wide_y >= STEP_Y) ? Y_W'(wide_y - STEP_Y) : '0;
        end else if (!down) begin
            mv_y = (wide_y + STEP_Y > Y_MAX) ? Y_W'(Y_MAX)
                                             : Y_W'(wide_y + STEP_Y);
        end else if (!left) begin
            mv_x = (wide_x >= STEP_X) ? X_W'(wide_x - STEP_X) : '0;
        end else if (!right) begin
            mv_x = (wide_x + STEP_X > X_MAX) ? X_W'(X_MAX)
                                             : X_W'(wide_x + STEP_X);
        end
    end

    always_comb begin
        state_n = state;
        busy = (state != IDLE);
        done = 1'b0;
        base_x = (state == ERASE) ? pos_x : new_x;
        base_y = (state == ERASE) ? pos_y : new_y;
        last = (cx == CX_LAST) && (cy == CY_LAST);
        unique case (state)
            IDLE:  if (!load && go) state_n = MOVE;
            MOVE:  state_n = (drawn && (mv_x != pos_x || mv_y != pos_y))
                             ? ERASE : DRAW;
            ERASE: if (flushing) state_n = DRAW;
            DRAW:  if (flushing) state_n = FIN;
            FIN: begin
                done = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end

    // Pixel outputs trail the address by one cycle to match ROM latency.
    assign colour = draw_q ? rom_data : colour_q;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            pos_x    <= '0;
            pos_y    <= '0;
            new_x    <= '0;
            new_y    <= '0;
            drawn    <= 1'b0;
            cx       <= '0;
            cy       <= '0;
            rom_addr <= '0;
            flushing <= 1'b0;
            plot     <= 1'b0;
            vga_x    <= '0;
            vga_y    <= '0;
            colour_q <= '0;
            draw_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (load) begin
                        pos_x <= init_x;
                        pos_y <= init_y;
                        drawn <= 1'b0;
                    end
                end
                MOVE: begin
                    new_x    <= mv_x;
                    new_y    <= mv_y;
                    cx       <= '0;
                    cy       <= '0;
                    rom_addr <= '0;
                    flushing <= 1'b0;
                end
                ERASE, DRAW: begin
                    if (flushing) begin
                        flushing <= 1'b0;
                        plot     <= 1'b0;
                        draw_q   <= 1'b0;
                        if (state == DRAW) begin
                            pos_x <= new_x;
                            pos_y <= new_y;
                            drawn <= 1'b1;
                        end
                    end else begin
                        plot     <= 1'b1;
                        vga_x    <= base_x + X_W'(cx);
                        vga_y    <= base_y + Y_W'(cy);
                        colour_q <= BG_COLOUR;
                        draw_q   <= (state == DRAW);
                        rom_addr <= last ? '0 : rom_addr + ADDR_W'(1);
                        if (cx == CX_LAST) begin
                            cx <= '0;
                            if (cy == CY_LAST) begin
                                cy       <= '0;
                                flushing <= 1'b1;
                            end else begin
                                cy <= cy + CY_W'(1);
                            end
                        end else begin
                            cx <= cx + CX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_animator.sv
// tb_sprite_animator: random and directed moves checked cycle by cycle
// against a plot-list model of the sprite animator.
`timescale 1ns/1ps
module tb_sprite_animator;
    localparam int X_W = 8;
    localparam int Y_W = 7;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int SPR_W = 20;
    localparam int SPR_H = 20;
    localparam int STEP = 7;
    localparam int ADDR_W = 9;
    localparam int BG = 0;
    localparam int N = SPR_W * SPR_H;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic go = 1'b0, load = 1'b0;
    logic [X_W-1:0] init_x = '0;
    logic [Y_W-1:0] init_y = '0;
    logic up = 1'b1, down = 1'b1, left = 1'b1, right = 1'b1;
    logic [ADDR_W-1:0] rom_addr;
    logic [2:0] rom_data = '0;
    logic [X_W-1:0] vga_x, pos_x;
    logic [Y_W-1:0] vga_y, pos_y;
    logic [2:0] colour;
    logic plot, busy, done;

    sprite_animator #(
        .X_W(X_W), .Y_W(Y_W), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H),
        .SPR_W(SPR_W), .SPR_H(SPR_H), .STEP(STEP), .ADDR_W(ADDR_W),
        .BG_COLOUR(3'b000)
    ) dut (
        .clock(clock), .resetn(resetn), .go(go), .load(load),
        .init_x(init_x), .init_y(init_y),
        .up(up), .down(down), .left(left), .right(right),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .vga_x(vga_x), .vga_y(vga_y), .colour(colour), .plot(plot),
        .pos_x(pos_x), .pos_y(pos_y), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    function automatic logic [2:0] rom_f(input int a);
        return 3'(a ^ (a >> 3) ^ (a >> 5));
    endfunction

    always @(posedge clock) rom_data <= rom_f(int'(rom_addr));

    typedef struct { int c; int x; int y; int col; } pix_t;
    typedef struct { int c; int x; int y; bit d; } pev_t;

    pix_t pq[$];
    pev_t pos_ev[$];
    int cyc = 0;
    int checks = 0, passes = 0, fails = 0;
    int m_x = 0, m_y = 0;
    bit m_drawn = 0;
    int exp_done = -1, busy_lo = -1, busy_hi = -2;
    int last_done = -1, plot_seen = 0;
    bit rst_pend = 0, active = 0;
    int rst_cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) begin
            passes++;
        end else begin
            fails++;
            if (fails <= 20)
                $display("FAIL %s cyc=%0d got %0d want %0d",
                         name, cyc, act, exp);
        end
    endtask

    always @(negedge clock) begin
        bit ep;
        if (rst_pend && cyc >= rst_cyc) begin
            pq.delete();
            pos_ev.delete();
            exp_done = -1;
            busy_lo = -1;
            busy_hi = -2;
            m_x = 0;
            m_y = 0;
            m_drawn = 0;
            rst_pend = 0;
        end
        while (pos_ev.size() > 0 && cyc >= pos_ev[0].c) begin
            m_x = pos_ev[0].x;
            m_y = pos_ev[0].y;
            m_drawn = pos_ev[0].d;
            pos_ev.delete(0);
        end
        if (active) begin
            while (pq.size() > 0 && pq[0].c < cyc) pq.delete(0);
            ep = (pq.size() > 0 && pq[0].c == cyc);
            chk("plot", int'(plot), int'(ep));
            if (ep) begin
                chk("vga_x", int'(vga_x), pq[0].x);
                chk("vga_y", int'(vga_y), pq[0].y);
                chk("colour", int'(colour), pq[0].col);
                pq.delete(0);
            end
            if (plot) plot_seen++;
            chk("done", int'(done), int'(cyc == exp_done));
            if (done) last_done = cyc;
            chk("busy", int'(busy), int'(cyc >= busy_lo && cyc <= busy_hi));
            chk("pos_x", int'(pos_x), m_x);
            chk("pos_y", int'(pos_y), m_y);
        end
    end

    // k = {up, down, left, right}, active-low.
    task automatic launch(input logic [3:0] k, output int g, output int dn);
        int nx, ny, d0;
        bit er;
        pix_t p;
        @(posedge clock); #1;
        g = cyc + 1;
        nx = m_x;
        ny = m_y;
        if (!k[3]) ny = (m_y >= STEP) ? m_y - STEP : 0;
        else if (!k[2]) ny = (m_y + STEP < SCREEN_H - SPR_H)
                             ? m_y + STEP : SCREEN_H - SPR_H;
        else if (!k[1]) nx = (m_x >= STEP) ? m_x - STEP : 0;
        else if (!k[0]) nx = (m_x + STEP < SCREEN_W - SPR_W)
                             ? m_x + STEP : SCREEN_W - SPR_W;
        er = m_drawn && (nx != m_x || ny != m_y);
        if (er) begin
            for (int i = 0; i < N; i++) begin
                p.c = g + 2 + i;
                p.x = (m_x + i % SPR_W) % 256;
                p.y = (m_y + i / SPR_W) % 128;
                p.col = BG;
                pq.push_back(p);
            end
        end
        d0 = er ? g + N + 3 : g + 2;
        for (int i = 0; i < N; i++) begin
            p.c = d0 + i;
            p.x = (nx + i % SPR_W) % 256;
            p.y = (ny + i / SPR_W) % 128;
            p.col = int'(rom_f(i));
            pq.push_back(p);
        end
        dn = d0 + N;
        exp_done = dn;
        busy_lo = g;
        busy_hi = dn;
        pos_ev.push_back('{c: dn, x: nx, y: ny, d: 1'b1});
        plot_seen = 0;
        {up, down, left, right} = k;
        go = 1'b1;
        @(posedge clock); #1;
        go = 1'b0;
        @(posedge clock); #1;
        {up, down, left, right} = 4'($urandom);
    endtask

    task automatic finish_seq(input int dn);
        while (cyc <= dn) @(posedge clock);
        #1;
        {up, down, left, right} = 4'hF;
        @(negedge clock); #1;
    endtask

    task automatic do_go(input logic [3:0] k, input bit poke, output int lat);
        int g, dn;
        launch(k, g, dn);
        if (poke) begin
            repeat (150) @(posedge clock);
            #1;
            go = 1'b1;
            load = 1'b1;
            init_x = 8'd99;
            init_y = 7'd9;
            @(posedge clock); #1;
            go = 1'b0;
            load = 1'b0;
        end
        finish_seq(dn);
        lat = last_done - g + 1;
    endtask

    task automatic do_load(input int x, input int y, input bit with_go);
        @(posedge clock); #1;
        init_x = X_W'(x);
        init_y = Y_W'(y);
        load = 1'b1;
        go = with_go;
        pos_ev.push_back('{c: cyc + 1, x: x, y: y, d: 1'b0});
        @(posedge clock); #1;
        load = 1'b0;
        go = 1'b0;
        @(negedge clock); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int lat, g, dn, guard;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_plot", int'(plot), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pos_x", int'(pos_x), 0);
        chk("rst_pos_y", int'(pos_y), 0);
        chk("rst_vga_x", int'(vga_x), 0);
        chk("rst_vga_y", int'(vga_y), 0);
        chk("rst_colour", int'(colour), 0);
        chk("rst_rom_addr", int'(rom_addr), 0);
        @(posedge clock); #1;
        resetn = 1'b1;
        active = 1;

        do_load(50, 60, 0);
        do_go(4'hF, 0, lat);
        chk("t1_plots", plot_seen, 400);
        chk("t1_lat", lat, 403);
        chk("t1_pos_x", int'(pos_x), 50);
        chk("t1_pos_y", int'(pos_y), 60);

        do_go(4'b1110, 0, lat);
        chk("t2_plots", plot_seen, 800);
        chk("t2_lat", lat, 804);
        chk("t2_pos_x", int'(pos_x), 57);
        chk("t2_pos_y", int'(pos_y), 60);

        do_load(3, 100, 0);
        do_go(4'hF, 0, lat);
        do_go(4'b1001, 1, lat);
        chk("t3_plots", plot_seen, 400);
        chk("t3_lat", lat, 403);
        chk("t3_pos_x", int'(pos_x), 3);
        chk("t3_pos_y", int'(pos_y), 100);

        do_load(3, 40, 0);
        do_go(4'hF, 0, lat);
        do_go(4'b1101, 0, lat);
        chk("t4_plots", plot_seen, 800);
        chk("t4_pos_x", int'(pos_x), 0);
        chk("t4_pos_y", int'(pos_y), 40);

        launch(4'b1110, g, dn);
        guard = 0;
        while (plot_seen < 150 && guard < 2000) begin
            @(posedge clock); #1;
            guard++;
        end
        chk("t5_reach150", int'(plot_seen >= 150), 1);
        resetn = 1'b0;
        rst_cyc = cyc + 1;
        rst_pend = 1;
        @(posedge clock); #1;
        resetn = 1'b1;
        @(negedge clock); #1;
        chk("t5_plot", int'(plot), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_pos_x", int'(pos_x), 0);
        chk("t5_pos_y", int'(pos_y), 0);
        {up, down, left, right} = 4'hF;
        do_go(4'hF, 0, lat);
        chk("t6_plots", plot_seen, 400);
        chk("t6_lat", lat, 403);
        chk("t6_pos_x", int'(pos_x), 0);

        for (int it = 0; it < 24; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 2)
                do_load($urandom_range(0, 150), $urandom_range(0, 110), 0);
            else if (r == 2)
                do_load($urandom_range(0, 150), $urandom_range(0, 110), 1);
            else
                do_go(4'($urandom), $urandom_range(0, 3) == 0, lat);
        end

        repeat (3) @(negedge clock);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
